// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions: frame constants and the receiver state encoding.
package uart_pkg;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      RX_IDLE       = 3'd0,
      RX_START      = 3'd1,
      RX_DATA       = 3'd2,
      RX_STOP       = 3'd3,
      RX_BREAK_WAIT = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset to RESET_VAL.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit start validation, centre sampling of 8 data bits LSB-first,
// stop-bit check, one-cycle valid / framing-error strobes and break hold-off.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       i_Clock,
   input  logic       i_Rst,
   input  logic       i_RX_Serial,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   output logic       o_RX_Active,
   output logic       o_RX_Framing_Err
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF       = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST       = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_INDEX = 3'(UART_DATA_BITS - 1);

   logic      rx_s;
   rx_state_t state, state_n;
   logic [CW-1:0] count, count_n;
   logic [2:0]    index, index_n;
   logic [7:0]    shift, shift_n;
   logic [7:0]    byte_n;
   logic          dv_n, ferr_n, active_n;

   sync_2ff #(
      .RESET_VAL (UART_IDLE_LEVEL)
   ) u_sync (
      .clk (i_Clock),
      .rst (i_Rst),
      .d   (i_RX_Serial),
      .q   (rx_s)
   );

   always_ff @(posedge i_Clock or posedge i_Rst) begin
      if (i_Rst) begin
         state            <= RX_IDLE;
         count            <= '0;
         index            <= '0;
         shift            <= '0;
         o_RX_Byte        <= 8'h00;
         o_RX_DV          <= 1'b0;
         o_RX_Framing_Err <= 1'b0;
         o_RX_Active      <= 1'b0;
      end else begin
         state            <= state_n;
         count            <= count_n;
         index            <= index_n;
         shift            <= shift_n;
         o_RX_Byte        <= byte_n;
         o_RX_DV          <= dv_n;
         o_RX_Framing_Err <= ferr_n;
         o_RX_Active      <= active_n;
      end
   end

   always_comb begin
      state_n  = state;
      count_n  = count;
      index_n  = index;
      shift_n  = shift;
      byte_n   = o_RX_Byte;
      dv_n     = 1'b0;
      ferr_n   = 1'b0;
      active_n = o_RX_Active;

      case (state)
         RX_IDLE: begin
            count_n = '0;
            index_n = '0;
            if (rx_s != UART_IDLE_LEVEL) begin
               state_n  = RX_START;
               active_n = 1'b1;
            end
         end

         // A start bit that has gone high again by mid-bit is a glitch, not a frame.
         RX_START: begin
            if (count == HALF) begin
               count_n = '0;
               if (rx_s != UART_IDLE_LEVEL) begin
                  state_n = RX_DATA;
               end else begin
                  state_n  = RX_IDLE;
                  active_n = 1'b0;
               end
            end else begin
               count_n = count + 1'b1;
            end
         end

         RX_DATA: begin
            if (count == LAST) begin
               count_n        = '0;
               shift_n[index] = rx_s;
               if (index == LAST_INDEX) begin
                  state_n = RX_STOP;
               end else begin
                  index_n = index + 3'd1;
               end
            end else begin
               count_n = count + 1'b1;
            end
         end

         RX_STOP: begin
            if (count == LAST) begin
               count_n  = '0;
               active_n = 1'b0;
               if (rx_s == UART_IDLE_LEVEL) begin
                  byte_n  = shift;
                  dv_n    = 1'b1;
                  state_n = RX_IDLE;
               end else begin
                  ferr_n  = 1'b1;
                  state_n = RX_BREAK_WAIT;
               end
            end else begin
               count_n = count + 1'b1;
            end
         end

         // A line held low after a bad stop bit is a break; wait for it to end.
         RX_BREAK_WAIT: begin
            count_n = '0;
            if (rx_s == UART_IDLE_LEVEL) begin
               state_n = RX_IDLE;
            end
         end

         default: begin
            state_n  = RX_IDLE;
            count_n  = '0;
            index_n  = '0;
            active_n = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: records the serial line per clock edge and predicts every
// receive event from the sampling-point rules, then compares against what the DUT produced.
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int HALF = (CPB - 1) / 2;
   localparam int MAXC = 40000;

   typedef struct {
      int cyc;
      int kind;
      int data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       dv;
   logic [7:0] rx_byte;
   logic       active;
   logic       ferr;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int overlap = 0;

   logic line_hist [MAXC];
   logic act_hist  [MAXC];
   logic act_exp   [MAXC];
   logic dv_hist   [MAXC];
   logic [7:0] byte_hist [MAXC];

   ev_t exp_q[$];
   ev_t obs_q[$];

   uart_rx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .i_Clock          (clk),
      .i_Rst            (rst),
      .i_RX_Serial      (rx),
      .o_RX_DV          (dv),
      .o_RX_Byte        (rx_byte),
      .o_RX_Active      (active),
      .o_RX_Framing_Err (ferr)
   );

   always #5 clk = ~clk;

   // Edge n samples the line value that the first synchroniser flop captures at that edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cyc + 1 < MAXC) line_hist[cyc + 1] <= rx;
   end

   always @(negedge clk) begin
      if (cyc < MAXC) begin
         act_hist[cyc]  = active;
         dv_hist[cyc]   = dv;
         byte_hist[cyc] = rx_byte;
      end
      if (!rst) begin
         if (dv && ferr) overlap++;
         if (dv)   obs_q.push_back('{cyc, 0, int'(rx_byte)});
         if (ferr) obs_q.push_back('{cyc, 1, int'(rx_byte)});
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic hold(input logic v, input int n);
      if (n > 0) begin
         rx = v;
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input int bit_clks, input logic stop);
      hold(1'b0, bit_clks);
      for (int k = 0; k < 8; k++) hold(b[k], bit_clks);
      hold(stop, bit_clks);
   endtask

   // Reference: a frame whose line goes low at edge E1 is judged at edges S(j) = E1+3+HALF+j*CPB,
   // each seeing the line two edges earlier; j=0 is the start check, 1..8 data, 9 the stop bit.
   task automatic model_segment(input int lo, input int hi);
      int p, e1, s0, q, exit_edge;
      logic [7:0] b;
      logic [7:0] last_good;
      last_good = 8'h00;
      p = lo;
      while (p < hi) begin
         if (line_hist[p] !== 1'b0) begin
            p++;
         end else begin
            e1 = p;
            s0 = e1 + 3 + HALF;
            exit_edge = s0;
            if (line_hist[s0 - 2] !== 1'b0) begin
               p = s0 - 1;
            end else begin
               for (int k = 0; k < 8; k++) b[k] = line_hist[s0 + (k + 1) * CPB - 2];
               exit_edge = s0 + 9 * CPB;
               if (exit_edge >= hi) begin
                  p = hi;
               end else if (line_hist[exit_edge - 2] === 1'b1) begin
                  exp_q.push_back('{exit_edge, 0, int'(b)});
                  last_good = b;
                  p = exit_edge - 1;
               end else begin
                  exp_q.push_back('{exit_edge, 1, int'(last_good)});
                  q = exit_edge - 1;
                  while (q < hi && line_hist[q] !== 1'b1) q++;
                  p = q + 1;
               end
            end
            for (int c = e1 + 2; c < exit_edge && c < hi; c++) act_exp[c] = 1'b1;
         end
      end
   endtask

   initial begin
      int r1, r2, rst_cyc, end_cyc, e1a, e1g, nbad, n;
      logic [7:0] b;
      int bit_clks;
      logic stop;

      for (int c = 0; c < MAXC; c++) act_exp[c] = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_dv", dv, 1'b0);
      check("rst_byte", rx_byte, 8'h00);
      check("rst_active", active, 1'b0);
      check("rst_ferr", ferr, 1'b0);
      rst = 1'b0;
      r1 = cyc + 1;

      hold(1'b1, 20);
      e1a = cyc + 1;
      send_frame(8'hA5, CPB, 1'b1);
      hold(1'b1, 20);

      send_frame(8'h00, CPB, 1'b1);
      send_frame(8'hFF, CPB, 1'b1);
      hold(1'b1, 10);
      send_frame(8'h55, CPB, 1'b1);
      hold(1'b1, 20);

      e1g = cyc + 1;
      hold(1'b0, 4);
      hold(1'b1, 20);
      send_frame(8'h3C, CPB, 1'b1);
      hold(1'b1, 20);

      send_frame(8'h81, CPB, 1'b0);
      hold(1'b0, 40);
      hold(1'b1, 20);
      send_frame(8'h42, CPB, 1'b1);
      hold(1'b1, 20);

      // At 15 clocks/bit the drift passes half a bit by the seventh data bit; the model predicts it.
      send_frame(8'h96, 17, 1'b1);
      hold(1'b1, 20);
      send_frame(8'h96, 15, 1'b1);
      hold(1'b1, 20);

      for (int i = 0; i < 40; i++) begin
         b = 8'($urandom);
         n = $urandom_range(0, 5);
         bit_clks = (n == 0) ? 15 : (n == 1) ? 17 : CPB;
         stop = ($urandom_range(0, 7) != 0);
         send_frame(b, bit_clks, stop);
         if (!stop) hold(1'b0, $urandom_range(0, 40));
         hold(1'b1, $urandom_range(0, 30));
         if ($urandom_range(0, 9) == 0) begin
            hold(1'b0, $urandom_range(1, 6));
            hold(1'b1, $urandom_range(10, 30));
         end
      end
      hold(1'b1, 200);

      hold(1'b0, CPB);
      hold(1'b1, CPB);
      hold(1'b1, CPB);
      hold(1'b0, CPB);
      rx = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      rx  = 1'b1;
      rst_cyc = cyc;
      #1;
      check("midrst_dv", dv, 1'b0);
      check("midrst_byte", rx_byte, 8'h00);
      check("midrst_active", active, 1'b0);
      check("midrst_ferr", ferr, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      r2 = cyc + 1;
      hold(1'b1, 20);
      send_frame(8'h7E, CPB, 1'b1);
      hold(1'b1, 200);
      end_cyc = cyc;

      if (end_cyc + 200 >= MAXC) begin
         $display("FAIL history_overflow got %0d expected below %0d", end_cyc + 200, MAXC);
         $fatal(1, "history buffer too small");
      end

      check("a5_dv_before", dv_hist[e1a + 153], 1'b0);
      check("a5_dv", dv_hist[e1a + 154], 1'b1);
      check("a5_byte", byte_hist[e1a + 154], 8'hA5);
      check("a5_dv_after", dv_hist[e1a + 155], 1'b0);
      check("a5_act_pre", act_hist[e1a + 1], 1'b0);
      check("a5_act_start", act_hist[e1a + 2], 1'b1);
      check("a5_act_last", act_hist[e1a + 153], 1'b1);
      check("a5_act_end", act_hist[e1a + 154], 1'b0);
      check("glitch_act_hi", act_hist[e1g + 9], 1'b1);
      check("glitch_act_lo", act_hist[e1g + 10], 1'b0);

      model_segment(r1, rst_cyc);
      model_segment(r2, end_cyc + 1);

      check("event_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         check($sformatf("ev%0d_cyc", i), obs_q[i].cyc, exp_q[i].cyc);
         check($sformatf("ev%0d_kind", i), obs_q[i].kind, exp_q[i].kind);
         check($sformatf("ev%0d_byte", i), obs_q[i].data, exp_q[i].data);
      end

      nbad = 0;
      for (int c = r1; c <= end_cyc; c++) begin
         if (act_hist[c] !== act_exp[c]) begin
            if (nbad == 0) $display("FAIL active_first_bad_cycle got %0d expected none", c);
            nbad++;
         end
      end
      check("active_bad_cycles", nbad, 0);
      check("strobe_overlap", overlap, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
